// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and types for the instruction-fetch front end.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W     = 32;
  localparam int unsigned INST_W          = 32;
  localparam int unsigned PC_STEP_DEFAULT = 4;
  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {S_REQ, S_WAIT} fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: pipeline control, instruction-memory handshake and IF/ID output.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   stall_i;
  logic                   flush_i;
  logic [INST_ADDR_W-1:0] new_pc_i;
  logic                   inst_req_o;
  logic [INST_ADDR_W-1:0] inst_addr_o;
  logic                   inst_gnt_i;
  logic                   inst_rvalid_i;
  logic [INST_W-1:0]      inst_rdata_i;
  logic [INST_ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0]      if_inst_o;
  logic                   if_valid_o;

  modport master (
    input  stall_i, flush_i, new_pc_i, inst_gnt_i, inst_rvalid_i, inst_rdata_i,
    output inst_req_o, inst_addr_o, if_pc_o, if_inst_o, if_valid_o
  );

  modport slave (
    output stall_i, flush_i, new_pc_i, inst_gnt_i, inst_rvalid_i, inst_rdata_i,
    input  inst_req_o, inst_addr_o, if_pc_o, if_inst_o, if_valid_o
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register that catches a fetch response arriving while the output is stalled.
module fetch_skid_buf
  import if_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  fetch_pkt_t data_i,
  output fetch_pkt_t data_o,
  output logic       full_o
);

  fetch_pkt_t data_q, data_d;
  logic       full_q, full_d;

  // Clear wins over push so a flushed response can never be kept.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, runs a single-outstanding req/gnt/rvalid
// handshake and delivers {pc, inst, valid} to IF/ID under stall and flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned            PC_STEP  = PC_STEP_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  if_fetch_if.master   bus
);

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [INST_ADDR_W-1:0] req_pc_q, req_pc_d;
  logic                   kill_q, kill_d;
  fetch_pkt_t             out_q, out_d;
  logic                   valid_q, valid_d;

  logic       skid_push, skid_pop, skid_clear, skid_full;
  fetch_pkt_t skid_data;

  logic req_c;
  logic slot_free;
  logic live_rvalid;

  assign req_c       = ~rst & (state_q == S_REQ) & ~skid_full;
  assign slot_free   = ~valid_q | ~bus.stall_i;
  assign live_rvalid = (state_q == S_WAIT) & bus.inst_rvalid_i & ~kill_q;

  // Next-state, PC and output-slot update; flush overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    out_d      = out_q;
    valid_d    = valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (bus.flush_i) begin
      pc_d       = bus.new_pc_i;
      valid_d    = 1'b0;
      out_d.inst = ZERO_WORD;
      skid_clear = 1'b1;
      case (state_q)
        S_REQ: begin
          // An old-address request granted this cycle is still in flight.
          if (req_c && bus.inst_gnt_i) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.inst_rvalid_i) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_c && bus.inst_gnt_i) begin
            pc_d     = pc_q + INST_ADDR_W'(PC_STEP);
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_rvalid_i) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end
        end
        default: state_d = S_REQ;
      endcase

      if (slot_free) begin
        if (skid_full) begin
          out_d    = skid_data;
          valid_d  = 1'b1;
          skid_pop = 1'b1;
        end else if (live_rvalid) begin
          out_d.pc   = req_pc_q;
          out_d.inst = bus.inst_rdata_i;
          valid_d    = 1'b1;
        end else begin
          out_d.inst = ZERO_WORD;
          valid_d    = 1'b0;
        end
      end else if (live_rvalid) begin
        skid_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      kill_q   <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (skid_clear),
    .data_i  ({req_pc_q, bus.inst_rdata_i}),
    .data_o  (skid_data),
    .full_o  (skid_full)
  );

  assign bus.inst_req_o  = req_c;
  assign bus.inst_addr_o = pc_q;
  assign bus.if_pc_o     = out_q.pc;
  assign bus.if_inst_o   = out_q.inst;
  assign bus.if_valid_o  = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed per-cycle vector bench for if_fetch plus a hand-written reset-mid-transaction sequence.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic clk;
  logic rst;
  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(logic stall, logic flush, logic [31:0] new_pc, logic gnt,
                              logic rvalid, logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_pc, logic [31:0] e_inst);
    vec_t v;
    v.stall = stall;  v.flush = flush;   v.new_pc = new_pc;
    v.gnt   = gnt;    v.rvalid = rvalid; v.rdata  = rdata;
    v.e_req = e_req;  v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc  = e_pc;   v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    check("inst_req_o",  idx, 32'(bus.inst_req_o), 32'(e_req));
    check("inst_addr_o", idx, bus.inst_addr_o,     e_addr);
    check("if_valid_o",  idx, 32'(bus.if_valid_o), 32'(e_valid));
    check("if_pc_o",     idx, bus.if_pc_o,         e_pc);
    check("if_inst_o",   idx, bus.if_inst_o,       e_inst);
  endtask

  task automatic drive(input logic stall, input logic flush, input logic [31:0] new_pc,
                       input logic gnt, input logic rvalid, input logic [31:0] rdata);
    bus.stall_i       = stall;
    bus.flush_i       = flush;
    bus.new_pc_i      = new_pc;
    bus.inst_gnt_i    = gnt;
    bus.inst_rvalid_i = rvalid;
    bus.inst_rdata_i  = rdata;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Expected values are what the outputs show during the cycle, before its closing edge.
    //          stall flush new_pc        gnt  rv   rdata          req  addr          vld  pc            inst
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0));          // 0
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h2401_0005, 0, 32'h0000_0004, 0, 32'h0,         32'h0));          // 1
    vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0,         32'h2401_0005));  // 2
    vecs.push_back(mk(1, 0, 32'h0,         0, 1, 32'h1111_0004, 0, 32'h0000_0008, 1, 32'h0,         32'h2401_0005));  // 3
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0,         32'h2401_0005));  // 4
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0,         32'h2401_0005));  // 5
    vecs.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0,         32'h2401_0005));  // 6
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h0,         32'h2401_0005));  // 7
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h4,         32'h1111_0004));  // 8
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h2222_0008, 0, 32'h0000_000C, 0, 32'h4,         32'h0));          // 9
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h8,         32'h2222_0008));  // 10
    vecs.push_back(mk(0, 1, 32'hBFC0_0380, 0, 0, 32'h0,         0, 32'h0000_0010, 0, 32'h8,         32'h0));          // 11
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hBFC0_0380, 0, 32'h8,         32'h0));          // 12
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 32'hBFC0_0380, 0, 32'h8,         32'h0));          // 13
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hBFC0_0380, 0, 32'h8,         32'h0));          // 14
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h3333_0380, 0, 32'hBFC0_0384, 0, 32'h8,         32'h0));          // 15
    vecs.push_back(mk(0, 1, 32'h0000_1000, 1, 0, 32'h0,         1, 32'hBFC0_0384, 1, 32'hBFC0_0380, 32'h3333_0380)); // 16
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'hBAD0_0384, 0, 32'h0000_1000, 0, 32'hBFC0_0380, 32'h0));       // 17
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_1000, 0, 32'hBFC0_0380, 32'h0));       // 18
    vecs.push_back(mk(0, 1, 32'h0000_2000, 0, 1, 32'hBAD0_1000, 0, 32'h0000_1004, 0, 32'hBFC0_0380, 32'h0));       // 19
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_2000, 0, 32'hBFC0_0380, 32'h0));       // 20
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h4444_2000, 0, 32'h0000_2004, 0, 32'hBFC0_0380, 32'h0));       // 21
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         1, 32'h0000_2004, 1, 32'h2000,      32'h4444_2000)); // 22
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h2000,      32'h0));       // 23
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 32'h5555_FFFC, 0, 32'h0000_0000, 0, 32'h2000,      32'h0));       // 24
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h5555_FFFC)); // 25
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0004, 0, 32'hFFFF_FFFC, 32'h0));       // 26

    // Reset state while rst is held.
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outs(-1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].new_pc, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      #1;
      check_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst);
    end

    // Reset mid-S_WAIT, then a stray response to the pre-reset request.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs(100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6666_6666);
    #1;
    check_outs(101, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_outs(102, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Restart after reset: first fetch at RESET_PC with a two-cycle response latency.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    check_outs(103, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_outs(104, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_0000);
    #1;
    check_outs(105, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_outs(106, 1'b1, 32'h4, 1'b1, 32'h0, 32'h7777_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
